// File: rtl/tsip_pkg.sv
// Shared constants, payload layout and state encodings for the TSIP receive path.
package tsip_pkg;

  localparam logic [7:0] DLE                = 8'h10;
  localparam logic [7:0] ETX                = 8'h03;
  localparam logic [7:0] ID_PRIMARY_TIMING  = 8'h8F;
  localparam logic [7:0] SUB_PRIMARY_TIMING = 8'hAB;

  localparam int unsigned PRIMARY_TIMING_LEN = 17;
  localparam int unsigned CNT_W              = 5;

  // Byte offsets inside the unstuffed payload (offset 0 is the subcode).
  localparam int unsigned OFF_SUBCODE = 0;
  localparam int unsigned OFF_TOW     = 1;
  localparam int unsigned OFF_WEEK    = 5;
  localparam int unsigned OFF_UTC     = 7;
  localparam int unsigned OFF_FLAG    = 9;
  localparam int unsigned OFF_SEC     = 10;
  localparam int unsigned OFF_MIN     = 11;
  localparam int unsigned OFF_HOUR    = 12;
  localparam int unsigned OFF_DAY     = 13;
  localparam int unsigned OFF_MONTH   = 14;
  localparam int unsigned OFF_YEAR    = 15;

  // Link-level framing state (DLE / ETX handling).
  typedef enum logic [1:0] {
    US_HUNT,
    US_START,
    US_BODY,
    US_BODY_DLE
  } unstuff_state_t;

  // Packet-level state: what the current frame's payload is being used for.
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_PAYLOAD,
    FR_SKIP
  } frame_state_t;

endpackage

// File: rtl/tsip_unstuffer.sv
// TSIP link layer: finds DLE-ID frame starts, removes DLE stuffing and flags DLE-ETX ends.
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   flush             abandon any frame in progress and return to HUNT
//   rx_dv, rx_byte    received byte strobe and data
//   data_dv_c/data_c  unstuffed payload byte (also carries the ID when sof_c is set)
//   sof_c             frame start, data_c holds the packet ID
//   eof_c             unstuffed DLE ETX seen
//   stuff_err_c       DLE followed by neither DLE nor ETX; sof_c is raised with it
//   hunting           framer is idle, waiting for a DLE
module tsip_unstuffer
  import tsip_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       flush,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       data_dv_c,
  output logic [7:0] data_c,
  output logic       sof_c,
  output logic       eof_c,
  output logic       stuff_err_c,
  output logic       hunting
);

  unstuff_state_t state, state_d;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= US_HUNT;
    else          state <= state_d;
  end

  // Next-state and per-byte decode; outputs are valid in the strobe cycle.
  always_comb begin
    state_d     = state;
    data_dv_c   = 1'b0;
    data_c      = rx_byte;
    sof_c       = 1'b0;
    eof_c       = 1'b0;
    stuff_err_c = 1'b0;
    if (flush) begin
      state_d = US_HUNT;
    end else if (rx_dv) begin
      case (state)
        US_HUNT: begin
          if (rx_byte == DLE) state_d = US_START;
        end
        US_START: begin
          if (rx_byte == DLE || rx_byte == ETX) begin
            state_d = US_HUNT;
          end else begin
            sof_c   = 1'b1;
            state_d = US_BODY;
          end
        end
        US_BODY: begin
          if (rx_byte == DLE) state_d = US_BODY_DLE;
          else                data_dv_c = 1'b1;
        end
        US_BODY_DLE: begin
          if (rx_byte == DLE) begin
            data_dv_c = 1'b1;
            state_d   = US_BODY;
          end else if (rx_byte == ETX) begin
            eof_c   = 1'b1;
            state_d = US_HUNT;
          end else begin
            // Lone DLE: resynchronise by treating this byte as the next frame's ID.
            stuff_err_c = 1'b1;
            sof_c       = 1'b1;
            state_d     = US_BODY;
          end
        end
        default: state_d = US_HUNT;
      endcase
    end
  end

  assign hunting = (state == US_HUNT);

endmodule

// File: rtl/tsip_timing_decoder.sv
// TSIP Primary Timing (8F-AB) receiver: unstuffs the UART byte stream, validates the packet
// and publishes UTC time-of-day fields with a one-cycle data-valid strobe.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_rx_dv, i_rx_byte      UART RX byte strobe and data
//   o_thunder_packet_dv     one-cycle pulse, all o_thunder_* fields updated this cycle
//   o_thunder_*             decoded fields, held until the next good packet
//   o_frame_err             one-cycle pulse, a matching ID/subcode frame was discarded
module tsip_timing_decoder
  import tsip_pkg::*;
#(
  parameter logic [7:0]  PACKET_ID    = ID_PRIMARY_TIMING,
  parameter logic [7:0]  SUBCODE      = SUB_PRIMARY_TIMING,
  parameter int unsigned PAYLOAD_LEN  = PRIMARY_TIMING_LEN,
  parameter int unsigned TIMEOUT_CLKS = 100000
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_thunder_packet_dv,
  output logic [31:0] o_thunder_tow,
  output logic [15:0] o_thunder_week,
  output logic [15:0] o_thunder_utc_offset,
  output logic [7:0]  o_thunder_timing_flag,
  output logic [7:0]  o_thunder_seconds,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_month,
  output logic [15:0] o_thunder_year,
  output logic        o_frame_err
);

  localparam int unsigned       TO_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0]  LEN_CNT = CNT_W'(PAYLOAD_LEN);

  logic       us_data_dv;
  logic [7:0] us_data;
  logic       us_sof;
  logic       us_eof;
  logic       us_stuff_err;
  logic       us_hunting;

  logic              timeout_c;
  logic [TO_W-1:0]   idle_cnt;
  frame_state_t      frame, frame_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              wr_en;
  logic              commit_d;
  logic              err_d;
  logic [7:0]        shadow [PAYLOAD_LEN];

  tsip_unstuffer u_unstuffer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .flush       (timeout_c),
    .rx_dv       (i_rx_dv),
    .rx_byte     (i_rx_byte),
    .data_dv_c   (us_data_dv),
    .data_c      (us_data),
    .sof_c       (us_sof),
    .eof_c       (us_eof),
    .stuff_err_c (us_stuff_err),
    .hunting     (us_hunting)
  );

  // Idle timer: counts silent cycles while inside a frame, saturating at the last count.
  assign timeout_c = !us_hunting && !i_rx_dv && (idle_cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_rx_dv || us_hunting || timeout_c) idle_cnt <= '0;
    else if (idle_cnt != TO_LAST)                        idle_cnt <= idle_cnt + TO_W'(1);
  end

  // Packet-level next state: subcode check, length accounting, commit/reject decision.
  // The commit cycle (dv/err visible) is the frame's END cycle; the framer is already in
  // HUNT then, so a byte strobed in that cycle starts the next frame.
  always_comb begin
    frame_d  = frame;
    cnt_d    = cnt;
    wr_en    = 1'b0;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (timeout_c) begin
      frame_d = FR_IDLE;
      err_d   = (frame == FR_PAYLOAD);
    end else if (us_sof) begin
      err_d   = us_stuff_err && (frame == FR_PAYLOAD);
      cnt_d   = '0;
      frame_d = (us_data == PACKET_ID) ? FR_PAYLOAD : FR_SKIP;
    end else if (us_data_dv && frame == FR_PAYLOAD) begin
      if (cnt == LEN_CNT) begin
        err_d   = 1'b1;
        frame_d = FR_SKIP;
      end else if (cnt == '0 && us_data != SUBCODE) begin
        // Other subpackets of this ID are normal traffic, not errors.
        frame_d = FR_SKIP;
      end else begin
        wr_en = 1'b1;
        cnt_d = cnt + CNT_W'(1);
      end
    end else if (us_eof) begin
      frame_d = FR_IDLE;
      if (frame == FR_PAYLOAD) begin
        if (cnt == LEN_CNT) commit_d = 1'b1;
        else                err_d    = 1'b1;
      end
    end
  end

  // Shadow payload buffer; contents only matter once a full frame has been counted.
  always_ff @(posedge i_clk) begin
    if (wr_en) shadow[cnt] <= us_data;
  end

  // Packet state, strobes and atomic field update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame                 <= FR_IDLE;
      cnt                   <= '0;
      o_thunder_packet_dv   <= 1'b0;
      o_frame_err           <= 1'b0;
      o_thunder_tow         <= '0;
      o_thunder_week        <= '0;
      o_thunder_utc_offset  <= '0;
      o_thunder_timing_flag <= '0;
      o_thunder_seconds     <= '0;
      o_thunder_minutes     <= '0;
      o_thunder_hour        <= '0;
      o_thunder_day         <= '0;
      o_thunder_month       <= '0;
      o_thunder_year        <= '0;
    end else begin
      frame               <= frame_d;
      cnt                 <= cnt_d;
      o_thunder_packet_dv <= commit_d;
      o_frame_err         <= err_d;
      if (commit_d) begin
        o_thunder_tow         <= {shadow[OFF_TOW], shadow[OFF_TOW+1], shadow[OFF_TOW+2], shadow[OFF_TOW+3]};
        o_thunder_week        <= {shadow[OFF_WEEK], shadow[OFF_WEEK+1]};
        o_thunder_utc_offset  <= {shadow[OFF_UTC], shadow[OFF_UTC+1]};
        o_thunder_timing_flag <= shadow[OFF_FLAG];
        o_thunder_seconds     <= shadow[OFF_SEC];
        o_thunder_minutes     <= shadow[OFF_MIN];
        o_thunder_hour        <= shadow[OFF_HOUR];
        o_thunder_day         <= shadow[OFF_DAY];
        o_thunder_month       <= shadow[OFF_MONTH];
        o_thunder_year        <= {shadow[OFF_YEAR], shadow[OFF_YEAR+1]};
      end
    end
  end

endmodule

// File: tb/tb_tsip_timing_decoder.sv
// Bench for tsip_timing_decoder: table of directed frames, hand-written corner sequences,
// and random frames checked against a frame-level reference model.
module tb_tsip_timing_decoder;

  localparam int TO = 40;

  typedef struct packed {
    logic [31:0] tow;
    logic [15:0] week;
    logic [15:0] utc;
    logic [7:0]  flag;
    logic [7:0]  sec;
    logic [7:0]  minute;
    logic [7:0]  hour;
    logic [7:0]  day;
    logic [7:0]  month;
    logic [15:0] year;
  } fld_t;

  typedef struct {
    logic [7:0] id;
    int         len;
    logic [7:0] pay [0:19];
    bit         b2b;
    bit         exp_dv;
    bit         exp_err;
    fld_t       exp_f;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        dut_dv;
  logic [31:0] dut_tow;
  logic [15:0] dut_week;
  logic [15:0] dut_utc;
  logic [7:0]  dut_flag;
  logic [7:0]  dut_sec;
  logic [7:0]  dut_min;
  logic [7:0]  dut_hour;
  logic [7:0]  dut_day;
  logic [7:0]  dut_month;
  logic [15:0] dut_year;
  logic        dut_err;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_total = 0, err_total = 0, dv_double = 0;
  int exp_dv_total = 0, exp_err_total = 0;
  logic dv_prev = 1'b0;
  fld_t hold = '0;

  always #5 clk = ~clk;

  tsip_timing_decoder #(.TIMEOUT_CLKS(TO)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_rx_dv               (rx_dv),
    .i_rx_byte             (rx_byte),
    .o_thunder_packet_dv   (dut_dv),
    .o_thunder_tow         (dut_tow),
    .o_thunder_week        (dut_week),
    .o_thunder_utc_offset  (dut_utc),
    .o_thunder_timing_flag (dut_flag),
    .o_thunder_seconds     (dut_sec),
    .o_thunder_minutes     (dut_min),
    .o_thunder_hour        (dut_hour),
    .o_thunder_day         (dut_day),
    .o_thunder_month       (dut_month),
    .o_thunder_year        (dut_year),
    .o_frame_err           (dut_err)
  );

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (dut_dv) dv_total++;
    if (dut_dv && dv_prev) dv_double++;
    dv_prev = dut_dv;
    if (dut_err) err_total++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_fields(input string tag, input fld_t e);
    chk({tag, "_tow"},   dut_tow,          e.tow);
    chk({tag, "_week"},  32'(dut_week),    32'(e.week));
    chk({tag, "_utc"},   32'(dut_utc),     32'(e.utc));
    chk({tag, "_flag"},  32'(dut_flag),    32'(e.flag));
    chk({tag, "_sec"},   32'(dut_sec),     32'(e.sec));
    chk({tag, "_min"},   32'(dut_min),     32'(e.minute));
    chk({tag, "_hour"},  32'(dut_hour),    32'(e.hour));
    chk({tag, "_day"},   32'(dut_day),     32'(e.day));
    chk({tag, "_month"}, 32'(dut_month),   32'(e.month));
    chk({tag, "_year"},  32'(dut_year),    32'(e.year));
  endtask

  // Reference: fields are plain big-endian reads of the payload.
  function automatic fld_t fields_of(input logic [7:0] p [0:19]);
    fld_t f;
    f.tow    = (32'(p[1]) << 24) + (32'(p[2]) << 16) + (32'(p[3]) << 8) + 32'(p[4]);
    f.week   = 16'(p[5]) * 16'd256 + 16'(p[6]);
    f.utc    = 16'(p[7]) * 16'd256 + 16'(p[8]);
    f.flag   = p[9];
    f.sec    = p[10];
    f.minute = p[11];
    f.hour   = p[12];
    f.day    = p[13];
    f.month  = p[14];
    f.year   = 16'(p[15]) * 16'd256 + 16'(p[16]);
    return f;
  endfunction

  // Reference: outcome of one well-terminated frame from its ID, length and payload.
  function automatic void predict(input logic [7:0] id, input int len, input logic [7:0] pay [0:19],
                                  output bit dv, output bit err);
    dv = 0; err = 0;
    if (id != 8'h8F)             return;
    if (len == 0)                begin err = 1; return; end
    if (pay[0] != 8'hAB)         return;
    if (len == 17)               dv = 1;
    else                         err = 1;
  endfunction

  task automatic put(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_dv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int mx);
    if (mx > 0) idle($urandom_range(0, mx));
  endtask

  task automatic send_frame(input logic [7:0] id, input int len, input logic [7:0] pay [0:19], input int gmax);
    put(8'h10); gap(gmax);
    put(id);    gap(gmax);
    for (int i = 0; i < len; i++) begin
      put(pay[i]);
      if (pay[i] == 8'h10) begin gap(gmax); put(8'h10); end
      gap(gmax);
    end
    put(8'h10); gap(gmax);
    put(8'h03);
  endtask

  task automatic settle_and_check(input string tag);
    idle(3);
    #1;
    chk({tag, "_dv_count"},  32'(dv_total),  32'(exp_dv_total));
    chk({tag, "_err_count"}, 32'(err_total), 32'(exp_err_total));
    check_fields(tag, hold);
  endtask

  vec_t tbl [0:6];
  logic [7:0] base  [0:16];
  logic [7:0] base2 [0:16];
  logic [7:0] pay   [0:19];
  fld_t f_spec, f_sec16, f2;

  initial begin
    base  = '{8'hAB, 8'h00, 8'h01, 8'h51, 8'h80, 8'h08, 8'h9C, 8'h00, 8'h12,
              8'h03, 8'h2D, 8'h1E, 8'h0C, 8'h0F, 8'h07, 8'h07, 8'hE8};
    base2 = '{8'hAB, 8'h00, 8'h09, 8'h3A, 8'h80, 8'h08, 8'h9D, 8'hFF, 8'hF6,
              8'h80, 8'h3B, 8'h3B, 8'h17, 8'h1F, 8'h0C, 8'h07, 8'hE9};
    f_spec  = '{tow: 32'd86400, week: 16'd2204, utc: 16'd18, flag: 8'h03, sec: 8'd45,
                minute: 8'd30, hour: 8'd12, day: 8'd15, month: 8'd7, year: 16'd2024};
    f_sec16 = f_spec;
    f_sec16.sec = 8'd16;
    f2 = '{tow: 32'd604800, week: 16'd2205, utc: 16'hFFF6, flag: 8'h80, sec: 8'd59,
           minute: 8'd59, hour: 8'd23, day: 8'd31, month: 8'd12, year: 16'd2025};

    for (int r = 0; r < 7; r++) begin
      tbl[r].id = 8'h8F; tbl[r].len = 17; tbl[r].b2b = 0;
      tbl[r].exp_dv = 0; tbl[r].exp_err = 0;
      for (int i = 0; i < 20; i++) tbl[r].pay[i] = (i < 17) ? base[i] : 8'h00;
    end
    tbl[0].exp_dv = 1; tbl[0].exp_f = f_spec;
    tbl[1].pay[10] = 8'h10; tbl[1].exp_dv = 1; tbl[1].exp_f = f_sec16;
    tbl[2].len = 16; tbl[2].exp_err = 1; tbl[2].exp_f = f_sec16;
    tbl[3].pay[0] = 8'hAC; tbl[3].b2b = 1; tbl[3].exp_f = f_sec16;
    tbl[4].id = 8'h47; tbl[4].b2b = 1; tbl[4].exp_f = f_sec16;
    for (int i = 0; i < 17; i++) tbl[5].pay[i] = base2[i];
    tbl[5].b2b = 1; tbl[5].exp_dv = 1; tbl[5].exp_f = f2;
    tbl[6].len = 18; tbl[6].exp_err = 1; tbl[6].exp_f = f2;

    // Reset state.
    idle(3);
    #1;
    chk("reset_dv",  32'(dut_dv),  32'd0);
    chk("reset_err", 32'(dut_err), 32'd0);
    check_fields("reset", '0);
    rst_n = 1'b1;
    idle(2);

    // Directed table; b2b rows run straight into the next frame with no idle gap.
    for (int r = 0; r < 7; r++) begin
      send_frame(tbl[r].id, tbl[r].len, tbl[r].pay, 0);
      exp_dv_total  += int'(tbl[r].exp_dv);
      exp_err_total += int'(tbl[r].exp_err);
      hold = tbl[r].exp_f;
      if (!tbl[r].b2b) settle_and_check($sformatf("tbl%0d", r));
    end

    // dv appears in the cycle right after the ETX strobe, for one cycle only.
    for (int i = 0; i < 20; i++) pay[i] = (i < 17) ? base[i] : 8'h00;
    send_frame(8'h8F, 17, pay, 0);
    #1;
    chk("latency_dv_high", 32'(dut_dv), 32'd1);
    @(negedge clk);
    #1;
    chk("latency_dv_low", 32'(dut_dv), 32'd0);
    exp_dv_total++;
    hold = f_spec;
    settle_and_check("latency");

    // Stuffing error mid-payload; the byte after the lone DLE opens a new good frame.
    put(8'h10); put(8'h8F); put(8'hAB); put(8'h01); put(8'h10); put(8'h8F);
    for (int i = 0; i < 17; i++) put(base2[i]);
    put(8'h10); put(8'h03);
    exp_err_total++;
    exp_dv_total++;
    hold = f2;
    settle_and_check("stuff_err");

    // Reset during payload byte 8, then a complete frame.
    put(8'h10); put(8'h8F);
    for (int i = 0; i < 8; i++) put(base[i]);
    rx_dv = 1'b1; rx_byte = base[8]; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rx_dv = 1'b0;
    hold = '0;
    settle_and_check("midrst");
    send_frame(8'h8F, 17, pay, 0);
    exp_dv_total++;
    hold = f_spec;
    settle_and_check("after_rst");

    // Idle timeout after payload byte 5.
    put(8'h10); put(8'h8F);
    for (int i = 0; i < 6; i++) put(base2[i]);
    idle(TO - 3);
    #1;
    chk("timeout_early_err", 32'(err_total), 32'(exp_err_total));
    for (int i = 0; i < 20 && err_total == exp_err_total; i++) idle(1);
    exp_err_total++;
    settle_and_check("timeout");
    for (int i = 0; i < 20; i++) pay[i] = (i < 17) ? base2[i] : 8'h00;
    send_frame(8'h8F, 17, pay, 0);
    exp_dv_total++;
    hold = f2;
    settle_and_check("after_timeout");

    // Timeout of a skipped frame is silent.
    put(8'h10); put(8'h47); put(8'h01);
    idle(TO + 10);
    settle_and_check("skip_timeout");

    // Random frames against the reference model.
    for (int n = 0; n < 80; n++) begin
      logic [7:0] id;
      int len, kind, ng;
      bit dv, err;
      kind = $urandom_range(0, 5);
      id = 8'h8F;
      len = 17;
      for (int i = 0; i < 20; i++)
        pay[i] = ($urandom_range(0, 7) == 0) ? 8'h10 : 8'($urandom);
      pay[0] = 8'hAB;
      if (kind == 3) len = $urandom_range(0, 16);
      if (kind == 4) len = $urandom_range(18, 20);
      if (kind == 5) begin
        if ($urandom_range(0, 1) == 1) pay[0] = 8'($urandom);
        else begin
          id = 8'($urandom);
          while (id == 8'h10 || id == 8'h03) id = 8'($urandom);
        end
      end
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        logic [7:0] junk;
        junk = 8'($urandom);
        if (junk == 8'h10) junk = 8'h11;
        put(junk);
      end
      send_frame(id, len, pay, 2);
      predict(id, len, pay, dv, err);
      exp_dv_total  += int'(dv);
      exp_err_total += int'(err);
      if (dv) hold = fields_of(pay);
      settle_and_check($sformatf("rnd%0d", n));
    end

    chk("dv_never_consecutive", 32'(dv_double), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
